// File: rtl/sdpram_fifo_ctrl.sv
// Single-clock FIFO controller around a simple dual-port RAM with a 2-entry prefetch buffer.
// Optional registered almost-full flag enabled by defining SDPRAM_FIFO_AFULL_EN.
module sdpram_fifo_ctrl #(
   parameter int DEPTH        = 32,
   parameter int DW           = 32,
   parameter int AW           = $clog2(DEPTH),
   parameter int AFULL_THRESH = DEPTH - 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_s_valid,
   output logic          o_s_ready,
   input  logic [DW-1:0] i_s_data,
   output logic          o_m_valid,
   input  logic          i_m_ready,
   output logic [DW-1:0] o_m_data,
   output logic          o_ram_ena,
   output logic          o_ram_wea,
   output logic [AW-1:0] o_ram_addra,
   output logic [DW-1:0] o_ram_dina,
   output logic          o_ram_enb,
   output logic [AW-1:0] o_ram_addrb,
   input  logic [DW-1:0] i_ram_doutb,
   output logic [AW+1:0] o_count,
   output logic          o_afull
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW:0]   wr_ptr, rd_ptr, ram_cnt;
   logic          inflight, rdy_en;
   logic          push, pop, issue;
   logic [1:0]    ob_cnt, ob_cnt_nxt;
   logic [2:0]    pending;
   logic [DW-1:0] ob0, ob1, ob0_nxt, ob1_nxt;

   assign ram_cnt   = wr_ptr - rd_ptr;
   assign o_s_ready = rdy_en & (ram_cnt != FULL_CNT);
   assign push      = i_s_valid & o_s_ready;
   assign o_m_valid = (ob_cnt != 2'd0);
   assign o_m_data  = ob0;
   assign pop       = o_m_valid & i_m_ready;

   // Buffer occupancy after this cycle's pop, counting the word already in flight.
   assign pending = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
   assign issue   = (ram_cnt != '0) & (pending < 3'd2);

   assign o_ram_ena   = push;
   assign o_ram_wea   = push;
   assign o_ram_addra = push ? wr_ptr[AW-1:0] : '0;
   assign o_ram_dina  = push ? i_s_data : '0;
   assign o_ram_enb   = issue;
   assign o_ram_addrb = issue ? rd_ptr[AW-1:0] : '0;

   assign o_count = {1'b0, ram_cnt} + {{(AW+1){1'b0}}, inflight} + {{AW{1'b0}}, ob_cnt};

   always_comb begin
      ob0_nxt    = ob0;
      ob1_nxt    = ob1;
      ob_cnt_nxt = ob_cnt;
      if (pop) begin
         ob0_nxt    = ob1;
         ob_cnt_nxt = ob_cnt - 2'd1;
      end
      // Returning read data lands in the first slot left free after the shift.
      if (inflight) begin
         if (ob_cnt_nxt == 2'd0) begin
            ob0_nxt = i_ram_doutb;
         end else begin
            ob1_nxt = i_ram_doutb;
         end
         ob_cnt_nxt = ob_cnt_nxt + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         inflight <= 1'b0;
         rdy_en   <= 1'b0;
         ob_cnt   <= '0;
         ob0      <= '0;
         ob1      <= '0;
      end else begin
         rdy_en   <= 1'b1;
         inflight <= issue;
         ob_cnt   <= ob_cnt_nxt;
         ob0      <= ob0_nxt;
         ob1      <= ob1_nxt;
         if (push) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (issue) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

`ifdef SDPRAM_FIFO_AFULL_EN
   localparam logic [AW+1:0] AFULL_LVL = (AW+2)'(AFULL_THRESH);

   logic [AW+1:0] count_nxt;
   logic          afull;

   assign count_nxt = o_count + (AW+2)'(push) - (AW+2)'(pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         afull <= 1'b0;
      end else begin
         afull <= (count_nxt >= AFULL_LVL);
      end
   end

   assign o_afull = afull;
`else
   assign o_afull = 1'b0;
`endif

endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// Scoreboard bench for sdpram_fifo_ctrl: queue-based reference model, behavioural RAM,
// directed latency/fill/stream/reset phases plus a long randomized phase.
module tb_sdpram_fifo_ctrl;

   localparam int DEPTH = 32;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int THR   = DEPTH - 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          s_valid, s_ready;
   logic [DW-1:0] s_data;
   logic          m_valid, m_ready;
   logic [DW-1:0] m_data;
   logic          ram_ena, ram_wea, ram_enb;
   logic [AW-1:0] ram_addra, ram_addrb;
   logic [DW-1:0] ram_dina, ram_doutb;
   logic [AW+1:0] count;
   logic          afull;

   sdpram_fifo_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data),
      .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data),
      .o_ram_ena(ram_ena), .o_ram_wea(ram_wea), .o_ram_addra(ram_addra), .o_ram_dina(ram_dina),
      .o_ram_enb(ram_enb), .o_ram_addrb(ram_addrb), .i_ram_doutb(ram_doutb),
      .o_count(count), .o_afull(afull)
   );

   always #5 clk = ~clk;

   // Behavioural simple dual-port RAM, 1-cycle read latency, never reset.
   logic [DW-1:0] mem [DEPTH];
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      ram_doutb = '0;
   end
   always @(posedge clk) begin
      if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
      if (ram_enb) ram_doutb <= mem[ram_addrb];
   end

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else passed++;
   endtask

   // Reference model: words accepted but not yet delivered, with the cycle each was pushed.
   logic [DW-1:0] exp_q [$];
   int            cyc_q [$];
   int            cyc = 0;
   int            wr_cnt = 0;
   int            rd_cnt = 0;
   logic          up;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) up <= 1'b0;
      else        up <= 1'b1;
   end

   always @(negedge clk) begin
      int   sz;
      logic exp_valid;
      if (!rst_n) begin
         exp_q.delete();
         cyc_q.delete();
         wr_cnt = 0;
         rd_cnt = 0;
      end else begin
         sz = exp_q.size();
         chk("count", 64'(count), 64'(sz));
`ifdef SDPRAM_FIFO_AFULL_EN
         chk("afull", 64'(afull), 64'(sz >= THR));
`else
         chk("afull", 64'(afull), 64'(0));
`endif
         if (up && sz < DEPTH) chk("ready_open", 64'(s_ready), 64'(1));
         if (sz >= DEPTH + 2) chk("ready_full", 64'(s_ready), 64'(0));
         exp_valid = (sz > 0) && (cyc - cyc_q[0] >= 3);
         chk("valid", 64'(m_valid), 64'(exp_valid));
         if (m_valid && m_ready) begin
            if (sz == 0) begin
               checks++;
               $display("FAIL pop_empty: got pop with model empty at %0t", $time);
            end else begin
               chk("data", 64'(m_data), 64'(exp_q.pop_front()));
               void'(cyc_q.pop_front());
            end
         end
         chk("ram_ena", 64'(ram_ena), 64'(s_valid && s_ready));
         chk("ram_wea", 64'(ram_wea), 64'(s_valid && s_ready));
         if (s_valid && s_ready) begin
            chk("addra", 64'(ram_addra), 64'(wr_cnt % DEPTH));
            chk("dina", 64'(ram_dina), 64'(s_data));
            exp_q.push_back(s_data);
            cyc_q.push_back(cyc);
            wr_cnt++;
         end
         if (ram_enb) begin
            chk("addrb", 64'(ram_addrb), 64'(rd_cnt % DEPTH));
            rd_cnt++;
         end
      end
   end

   task automatic step(input logic v, input logic [DW-1:0] d, input logic r, output logic acc);
      s_valid = v;
      s_data  = d;
      m_ready = r;
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      logic acc;
      int   n = 0;
      while ((exp_q.size() != 0 || m_valid) && n < 100) begin
         step(1'b0, '0, 1'b1, acc);
         n++;
      end
      m_ready = 1'b0;
      chk({name, "_empty"}, 64'(exp_q.size()), 64'(0));
      chk({name, "_count"}, 64'(count), 64'(0));
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_s_ready"}, 64'(s_ready), 64'(0));
      chk({name, "_m_valid"}, 64'(m_valid), 64'(0));
      chk({name, "_m_data"}, 64'(m_data), 64'(0));
      chk({name, "_count"}, 64'(count), 64'(0));
      chk({name, "_afull"}, 64'(afull), 64'(0));
      chk({name, "_ena"}, 64'(ram_ena), 64'(0));
      chk({name, "_wea"}, 64'(ram_wea), 64'(0));
      chk({name, "_enb"}, 64'(ram_enb), 64'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic          acc;
      int            accepted;
      logic [DW-1:0] d;
      int            pv, pr;

      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

      // Reset and idle
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("rst");
      rst_n = 1'b1;
      chk("rdy_before_clk", 64'(s_ready), 64'(0));
      @(posedge clk); #1;
      chk("rdy_after_clk", 64'(s_ready), 64'(1));
      repeat (3) begin
         @(negedge clk);
         chk("idle_enb", 64'(ram_enb), 64'(0));
         @(posedge clk); #1;
      end

      // Single word latency
      s_valid = 1'b1; s_data = 32'hA5A5_0001;
      @(negedge clk);
      chk("sw_addra", 64'(ram_addra), 64'(0));
      chk("sw_ena", 64'(ram_ena), 64'(1));
      @(posedge clk); #1;
      s_valid = 1'b0;
      @(negedge clk);
      chk("sw_enb", 64'(ram_enb), 64'(1));
      chk("sw_addrb", 64'(ram_addrb), 64'(0));
      chk("sw_count1", 64'(count), 64'(1));
      @(posedge clk); #1;
      @(negedge clk);
      chk("sw_valid_t2", 64'(m_valid), 64'(0));
      chk("sw_count2", 64'(count), 64'(1));
      @(posedge clk); #1;
      @(negedge clk);
      chk("sw_valid_t3", 64'(m_valid), 64'(1));
      chk("sw_data", 64'(m_data), 64'(32'hA5A5_0001));
      chk("sw_count3", 64'(count), 64'(1));
      @(posedge clk); #1;
      drain("sw");

      // Fill with no pops
      accepted = 0;
      for (int i = 0; i < 50; i++) begin
         step(1'b1, 32'h1000_0000 + 32'(accepted), 1'b0, acc);
         if (acc) accepted++;
      end
      s_valid = 1'b0;
      chk("fill_accepted", 64'(accepted), 64'(DEPTH + 2));
      chk("fill_count", 64'(count), 64'(DEPTH + 2));
      chk("fill_ready", 64'(s_ready), 64'(0));
`ifdef SDPRAM_FIFO_AFULL_EN
      chk("fill_afull", 64'(afull), 64'(1));
`else
      chk("fill_afull", 64'(afull), 64'(0));
`endif
      drain("fill");

      // Streaming: one push and one pop per cycle
      for (int i = 0; i < 100; i++) begin
         s_valid = 1'b1; s_data = 32'h2000_0000 + 32'(i); m_ready = 1'b1;
         @(negedge clk);
         if (i >= 3) begin
            chk("stream_count", 64'(count), 64'(3));
            chk("stream_valid", 64'(m_valid), 64'(1));
         end
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      drain("stream");

      // Random traffic with three bias phases to reach full, balanced and empty regimes
      d = $urandom;
      for (int seg = 0; seg < 3; seg++) begin
         pv = (seg == 0) ? 80 : (seg == 1) ? 50 : 30;
         pr = (seg == 0) ? 30 : (seg == 1) ? 50 : 80;
         for (int i = 0; i < 3400; i++) begin
            step(($urandom % 100) < pv, d, ($urandom % 100) < pr, acc);
            if (acc) d = $urandom;
         end
      end
      s_valid = 1'b0;
      drain("rand");

      // Mid-run reset with a read in flight
      for (int i = 0; i < 11; i++) step(1'b1, 32'h3000_0000 + 32'(i), 1'b0, acc);
      repeat (4) step(1'b0, '0, 1'b0, acc);
      s_valid = 1'b0; m_ready = 1'b1;
      @(negedge clk);
      chk("mid_issue", 64'(ram_enb), 64'(1));
      @(posedge clk); #1;
      m_ready = 1'b0;
      chk("mid_count", 64'(count), 64'(10));
      rst_n = 1'b0;
      #1;
      chk_all_zero("mid_rst");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b0, '0, 1'b0, acc);
      for (int i = 0; i < 6; i++) step(1'b1, 32'h4000_0000 + 32'(i), 1'b0, acc);
      s_valid = 1'b0;
      repeat (4) step(1'b0, '0, 1'b0, acc);
      drain("post_rst");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
